// File: rtl/log_ram_writer_pkg.sv
// Shared definitions for the log RAM capture block: default geometry and FSM state encodings.
package log_ram_writer_pkg;

  localparam int NB_DATA_DEF = 16;
  localparam int NB_ADDR_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/log_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read-first read port.
module log_dpram #(
  parameter int DATA_W  = 32,
  parameter int NB_ADDR = 11
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [DATA_W-1:0]  rd_data
);

  logic [DATA_W-1:0] mem [2**NB_ADDR];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Non-blocking read in a separate process returns the pre-write word on a collision.
  always_ff @(posedge clock) begin
    if (i_reset) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/log_ram_writer.sv
// Capture side of the log RAM: arms on a rising edge of i_run and fills the RAM from address 0.
module log_ram_writer
  import log_ram_writer_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_valid,
  input  logic [2*NB_DATA-1:0] i_data,
  input  logic [NB_ADDR-1:0]   i_read_addr,
  output logic [2*NB_DATA-1:0] o_read_data,
  output logic                 o_full,
  output logic                 o_busy,
  output logic [NB_ADDR:0]     o_wr_count
);

  localparam logic [NB_ADDR-1:0] PTR_ONE  = NB_ADDR'(1);
  localparam logic [NB_ADDR-1:0] PTR_LAST = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR:0]   CNT_ONE  = (NB_ADDR+1)'(1);

  state_t             state, state_nxt;
  logic [NB_ADDR-1:0] wr_ptr, wr_ptr_nxt;
  logic [NB_ADDR:0]   wr_count_nxt;
  logic               run_d;
  logic               start;
  logic               wr_en;

  assign start = i_run & ~run_d;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      run_d      <= 1'b0;
      o_full     <= 1'b0;
      o_busy     <= 1'b0;
      o_wr_count <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      run_d      <= i_run;
      o_full     <= (state_nxt == ST_FULL);
      o_busy     <= (state_nxt == ST_CAPTURE);
      o_wr_count <= wr_count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    wr_count_nxt = o_wr_count;
    wr_en        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_CAPTURE;
          wr_ptr_nxt   = '0;
          wr_count_nxt = '0;
        end
      end
      ST_CAPTURE: begin
        if (i_valid) begin
          wr_en        = ~i_reset;
          wr_ptr_nxt   = wr_ptr + PTR_ONE;
          wr_count_nxt = o_wr_count + CNT_ONE;
          if (wr_ptr == PTR_LAST) state_nxt = ST_FULL;
        end
        // Abort wins over full: a last-word write with i_run low still lands, but o_full stays 0.
        if (!i_run) state_nxt = ST_IDLE;
      end
      ST_FULL: begin
        if (!i_run) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  log_dpram #(
    .DATA_W  (2*NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .clock   (clock),
    .i_reset (i_reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (i_data),
    .rd_addr (i_read_addr),
    .rd_data (o_read_data)
  );

endmodule

// File: tb/tb_log_ram_writer.sv
// Self-checking bench for log_ram_writer with a 16-word buffer of 32-bit words.
module tb_log_ram_writer;

  localparam int NB_DATA = 16;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 2**NB_ADDR;

  logic                 clock = 1'b0;
  logic                 i_reset;
  logic                 i_run;
  logic                 i_valid;
  logic [2*NB_DATA-1:0] i_data;
  logic [NB_ADDR-1:0]   i_read_addr;
  logic [2*NB_DATA-1:0] o_read_data;
  logic                 o_full;
  logic                 o_busy;
  logic [NB_ADDR:0]     o_wr_count;

  typedef struct {
    logic        run;
    logic        valid;
    logic [31:0] data;
    logic        busy;
    logic        full;
    int          count;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  log_ram_writer #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_run       (i_run),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_read_addr (i_read_addr),
    .o_read_data (o_read_data),
    .o_full      (o_full),
    .o_busy      (o_busy),
    .o_wr_count  (o_wr_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic busy, input logic full, input int count);
    check({tag, ".busy"},  {31'd0, o_busy}, {31'd0, busy});
    check({tag, ".full"},  {31'd0, o_full}, {31'd0, full});
    check({tag, ".count"}, 32'(o_wr_count), 32'(count));
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    i_valid = 1'b1;
    i_data  = data;
    tick();
    exp_mem[addr] = data;
    i_valid = 1'b0;
  endtask

  task automatic rd(input int addr);
    i_read_addr = NB_ADDR'(addr);
    exp_q.push_back(exp_mem[addr]);
    tick();
    check($sformatf("read[%0d]", addr), o_read_data, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Abort sequence: four writes, then a fifth in the same cycle i_run drops.
    vecs[0] = '{run:1'b0, valid:1'b0, data:32'h0,         busy:1'b0, full:1'b0, count:16};
    vecs[1] = '{run:1'b1, valid:1'b1, data:32'h0000_EEEE, busy:1'b1, full:1'b0, count:0};
    vecs[2] = '{run:1'b1, valid:1'b1, data:32'h0000_0200, busy:1'b1, full:1'b0, count:1};
    vecs[3] = '{run:1'b1, valid:1'b1, data:32'h0000_0201, busy:1'b1, full:1'b0, count:2};
    vecs[4] = '{run:1'b1, valid:1'b1, data:32'h0000_0202, busy:1'b1, full:1'b0, count:3};
    vecs[5] = '{run:1'b1, valid:1'b1, data:32'h0000_0203, busy:1'b1, full:1'b0, count:4};
    vecs[6] = '{run:1'b0, valid:1'b1, data:32'h0000_0204, busy:1'b0, full:1'b0, count:5};
    vecs[7] = '{run:1'b0, valid:1'b1, data:32'h0000_0999, busy:1'b0, full:1'b0, count:5};

    i_reset = 1'b1; i_run = 1'b0; i_valid = 1'b0; i_data = '0; i_read_addr = '0;
    tick(); tick();
    chk_ctl("reset", 1'b0, 1'b0, 0);
    check("reset.read_data", o_read_data, 32'h0);
    i_reset = 1'b0;
    tick();
    chk_ctl("idle", 1'b0, 1'b0, 0);

    // Full contiguous capture; the start-cycle sample must not be stored.
    i_run = 1'b1; i_valid = 1'b1; i_data = 32'hDEAD_BEEF;
    tick();
    i_valid = 1'b0;
    chk_ctl("start1", 1'b1, 1'b0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      write_word(k, 32'(k));
      chk_ctl($sformatf("cap1[%0d]", k), k < DEPTH-1, k == DEPTH-1, k+1);
    end
    i_valid = 1'b1; i_data = 32'hFFFF_0000;
    tick();
    i_valid = 1'b0;
    chk_ctl("full1_hold", 1'b0, 1'b1, DEPTH);
    for (int k = 0; k < DEPTH; k++) rd(k);

    // Gapped capture followed by an ignored 17th sample.
    i_run = 1'b0;
    tick();
    chk_ctl("drop1", 1'b0, 1'b0, DEPTH);
    i_run = 1'b1;
    tick();
    chk_ctl("start2", 1'b1, 1'b0, 0);
    for (int j = 0; j < DEPTH; j++) begin
      write_word(j, 32'h100 + 32'(j));
      check($sformatf("cap2[%0d].count", j), 32'(o_wr_count), 32'(j+1));
      tick();
    end
    i_valid = 1'b1; i_data = 32'h0000_0BAD;
    tick();
    i_valid = 1'b0;
    chk_ctl("full2", 1'b0, 1'b1, DEPTH);
    for (int k = 0; k < DEPTH; k++) rd(k);

    for (int v = 0; v < 8; v++) begin
      i_run = vecs[v].run; i_valid = vecs[v].valid; i_data = vecs[v].data;
      tick();
      chk_ctl($sformatf("abort[%0d]", v), vecs[v].busy, vecs[v].full, vecs[v].count);
    end
    i_valid = 1'b0;
    for (int j = 0; j < 5; j++) exp_mem[j] = 32'h200 + 32'(j);
    for (int k = 0; k < DEPTH; k++) rd(k);

    // Reset mid-capture, then re-arm with i_run still high.
    i_run = 1'b1;
    tick();
    chk_ctl("start3", 1'b1, 1'b0, 0);
    for (int j = 0; j < 7; j++) write_word(j, 32'h300 + 32'(j));
    chk_ctl("cap3", 1'b1, 1'b0, 7);
    i_reset = 1'b1; i_valid = 1'b1; i_data = 32'h0000_0307;
    tick();
    i_valid = 1'b0;
    chk_ctl("midreset", 1'b0, 1'b0, 0);
    check("midreset.read_data", o_read_data, 32'h0);
    i_reset = 1'b0;
    tick();
    chk_ctl("rearm", 1'b1, 1'b0, 0);
    write_word(0, 32'h0000_0400);
    chk_ctl("rearm_w0", 1'b1, 1'b0, 1);
    rd(0);
    rd(1);

    // Same-address read/write collision returns the old word first.
    write_word(1, 32'h0000_0401);
    write_word(2, 32'h0000_0402);
    i_read_addr = NB_ADDR'(3);
    exp_q.push_back(exp_mem[3]);
    write_word(3, 32'h0000_0403);
    check("collide.old", o_read_data, exp_q.pop_front());
    rd(3);
    chk_ctl("collide", 1'b1, 1'b0, 4);
    i_run = 1'b0;
    tick();
    chk_ctl("final_idle", 1'b0, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
